// File: rtl/sram_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : sram_bus_pkg
//  Description : Shared encodings for the SRAM-like data bus: access-size
//                codes, responder FSM states and the byte-strobe decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_bus_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Lane strobes for an access; size 3 falls into the word case.
   function automatic logic [3:0] strobe_decode(input logic [1:0] sz,
                                                input logic [1:0] a);
      logic [3:0] s;
      case (sz)
         SZ_BYTE: s = 4'b0001 << a;
         SZ_HALF: s = a[1] ? 4'b1100 : 4'b0011;
         default: s = 4'b1111;
      endcase
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/data_sram_responder_lfsr16.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr16
//  Description : 16-bit Fibonacci LFSR, taps 16/14/13/11, seeded 16'hACE1.
//                Steps every cycle; used to jitter responder latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr16 (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] lfsr_o
);

   localparam logic [15:0] C_SEED = 16'hACE1;

   logic [15:0] lfsr_q;
   logic        fb;

   assign fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
   assign lfsr_o = lfsr_q;

   // Shift register advancing once per cycle.
   always_ff @(posedge clk) begin
      if (rst) lfsr_q <= C_SEED;
      else     lfsr_q <= {lfsr_q[14:0], fb};
   end

endmodule
`default_nettype wire

// File: rtl/data_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_sram_responder
//  Description : SRAM-like bus target serving one request at a time from an
//                internal word RAM, answering with a single data_ok pulse a
//                fixed LATENCY cycles after the handshake.
//                Optional macro RESP_RANDOM_DELAY_EN adds 0..3 cycles of
//                LFSR-driven latency and randomly withholds addr_ok.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_sram_responder
   import sram_bus_pkg::*;
#(
   parameter int ADDR_W  = 12,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata
);

   localparam int CW = 5;   // holds LATENCY+3 up to 18

   state_e              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                wr_q, wr_d;
   logic [1:0]          size_q, size_d;
   logic [ADDR_W+1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         rdata_q, rdata_d;
   logic [31:0]         mem [2**ADDR_W];

   logic                hs;
   logic                accept_gate;
   logic [1:0]          extra_lat;
   logic [CW-1:0]       lat_eff;
   logic [3:0]          strb;
   logic                unused_ok;

   // Address bits above the RAM window alias and are deliberately dropped.
   assign unused_ok = &{1'b0, addr[31:ADDR_W+2]};

`ifdef RESP_RANDOM_DELAY_EN
   logic [15:0] lfsr;
   logic        unused_lfsr;

   lfsr16 u_lfsr (
      .clk    (clk),
      .rst    (rst),
      .lfsr_o (lfsr)
   );

   assign extra_lat   = lfsr[1:0];
   assign accept_gate = ~lfsr[2];
   assign unused_lfsr = ^lfsr[15:3];
`else
   assign extra_lat   = 2'b00;
   assign accept_gate = 1'b1;
`endif

   assign lat_eff = CW'(LATENCY) + {{(CW-2){1'b0}}, extra_lat};
   assign hs      = req & addr_ok;
   assign strb    = strobe_decode(size_q, addr_q[1:0]);
   assign rdata   = rdata_q;

   // FSM state and countdown register; reset drops any pending request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state: countdown of the remaining wait cycles before RESP.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (hs) begin
               if (lat_eff <= CW'(1)) begin
                  state_d = ST_RESP;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = lat_eff - CW'(1);
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q <= CW'(1)) begin
               state_d = ST_RESP;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q - CW'(1);
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Bus handshake outputs decoded from the current state.
   always_comb begin
      addr_ok = (state_q == ST_IDLE) & ~rst & accept_gate;
      data_ok = (state_q == ST_RESP);
   end

   // Request capture and response data; read data is fetched on the edge
   // entering RESP so a read right after a committed write sees new data.
   always_comb begin
      wr_d    = hs ? wr    : wr_q;
      size_d  = hs ? size  : size_q;
      addr_d  = hs ? addr[ADDR_W+1:0] : addr_q;
      wdata_d = hs ? wdata : wdata_q;
      rdata_d = rdata_q;
      if (state_d == ST_RESP)
         rdata_d = wr_d ? 32'h0 : mem[addr_d[ADDR_W+1:2]];
   end

   // Request/response datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q    <= 1'b0;
         size_q  <= SZ_BYTE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         wr_q    <= wr_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // RAM write in the RESP cycle, strobed lanes only; reset blocks commit.
   always_ff @(posedge clk) begin
      if (!rst && state_q == ST_RESP && wr_q) begin
         for (int b = 0; b < 4; b++) begin
            if (strb[b]) mem[addr_q[ADDR_W+1:2]][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_data_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_sram_responder
//  Description : Directed self-checking bench. Three responders with
//                LATENCY 2, 1 and 4 are exercised independently.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_sram_responder;

   logic        clk = 1'b0;
   logic        rst_s     [3];
   logic        req_s     [3];
   logic        wr_s      [3];
   logic [1:0]  size_s    [3];
   logic [31:0] addr_s    [3];
   logic [31:0] wdata_s   [3];
   logic        addr_ok_s [3];
   logic        data_ok_s [3];
   logic [31:0] rdata_s   [3];

   int checks = 0;
   int errors = 0;
   logic [31:0] rd;

   always #5 clk = ~clk;

   data_sram_responder #(.ADDR_W(12), .LATENCY(2)) u_dut_l2 (
      .clk(clk), .rst(rst_s[0]), .req(req_s[0]), .wr(wr_s[0]), .size(size_s[0]),
      .addr(addr_s[0]), .wdata(wdata_s[0]), .addr_ok(addr_ok_s[0]),
      .data_ok(data_ok_s[0]), .rdata(rdata_s[0]));

   data_sram_responder #(.ADDR_W(12), .LATENCY(1)) u_dut_l1 (
      .clk(clk), .rst(rst_s[1]), .req(req_s[1]), .wr(wr_s[1]), .size(size_s[1]),
      .addr(addr_s[1]), .wdata(wdata_s[1]), .addr_ok(addr_ok_s[1]),
      .data_ok(data_ok_s[1]), .rdata(rdata_s[1]));

   data_sram_responder #(.ADDR_W(12), .LATENCY(4)) u_dut_l4 (
      .clk(clk), .rst(rst_s[2]), .req(req_s[2]), .wr(wr_s[2]), .size(size_s[2]),
      .addr(addr_s[2]), .wdata(wdata_s[2]), .addr_ok(addr_ok_s[2]),
      .data_ok(data_ok_s[2]), .rdata(rdata_s[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One complete transaction on responder sel, checking handshake timing.
   task automatic xfer(input int sel, input int lat, input logic w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, output logic [31:0] r);
      int n;
      @(negedge clk);
      req_s[sel] = 1'b1; wr_s[sel] = w; size_s[sel] = sz;
      addr_s[sel] = a; wdata_s[sel] = wd;
      #1 chk("addr_ok_at_T", 32'(addr_ok_s[sel]), 32'd1);
      @(negedge clk);
      // Scramble inputs after the handshake; the responder must have latched them.
      req_s[sel] = 1'b0; wr_s[sel] = ~w; size_s[sel] = 2'd0;
      addr_s[sel] = 32'hFFFF_FFFF; wdata_s[sel] = 32'h0;
      n = 1;
      while (data_ok_s[sel] !== 1'b1 && n < 40) begin
         chk("addr_ok_wait", 32'(addr_ok_s[sel]), 32'd0);
         @(negedge clk);
         n++;
      end
      chk("latency", 32'(n), 32'(lat));
      chk("addr_ok_resp", 32'(addr_ok_s[sel]), 32'd0);
      r = rdata_s[sel];
      if (w) chk("wr_resp_rdata", r, 32'h0);
      @(negedge clk);
      chk("data_ok_width", 32'(data_ok_s[sel]), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         rst_s[i] = 1'b1; req_s[i] = 1'b0; wr_s[i] = 1'b0;
         size_s[i] = 2'd0; addr_s[i] = '0; wdata_s[i] = '0;
      end
      repeat (3) @(negedge clk);
      chk("rst_addr_ok", 32'(addr_ok_s[0]), 32'd0);
      chk("rst_data_ok", 32'(data_ok_s[0]), 32'd0);
      chk("rst_rdata",   rdata_s[0], 32'h0);
      for (int i = 0; i < 3; i++) rst_s[i] = 1'b0;
      #1 chk("addr_ok_after_rst", 32'(addr_ok_s[0]), 32'd1);

      // Read after reset, LATENCY 2
      xfer(0, 2, 1'b0, 2'd2, 32'h0000_0010, 32'h0, rd);

      // Byte write into a preloaded word
      xfer(0, 2, 1'b1, 2'd2, 32'h0000_0100, 32'h1122_3344, rd);
      xfer(0, 2, 1'b1, 2'd0, 32'h0000_0103, 32'hAB00_0000, rd);
      xfer(0, 2, 1'b0, 2'd2, 32'h0000_0103, 32'h0, rd);
      chk("byte_write", rd, 32'hAB22_3344);

      // Halfword writes, upper then lower
      xfer(0, 2, 1'b1, 2'd2, 32'h0000_0200, 32'h0, rd);
      xfer(0, 2, 1'b1, 2'd1, 32'h0000_0202, 32'hBEEF_0000, rd);
      xfer(0, 2, 1'b0, 2'd2, 32'h0000_0200, 32'h0, rd);
      chk("half_hi", rd, 32'hBEEF_0000);
      xfer(0, 2, 1'b1, 2'd1, 32'h0000_0200, 32'h0000_CAFE, rd);
      xfer(0, 2, 1'b0, 2'd2, 32'h0000_0200, 32'h0, rd);
      chk("half_lo", rd, 32'hBEEF_CAFE);

      // Size 3 acts as word ignoring addr[1:0]; then byte in lane 1
      xfer(0, 2, 1'b1, 2'd3, 32'h0000_0302, 32'h0102_0304, rd);
      xfer(0, 2, 1'b0, 2'd2, 32'h0000_0300, 32'h0, rd);
      chk("size3_word", rd, 32'h0102_0304);
      xfer(0, 2, 1'b1, 2'd0, 32'h0000_0301, 32'h0000_AA00, rd);
      xfer(0, 2, 1'b0, 2'd0, 32'h0000_0300, 32'h0, rd);
      chk("byte_lane1", rd, 32'h0102_AA04);

      // Aliasing modulo 2^14 bytes
      xfer(0, 2, 1'b1, 2'd2, 32'h0000_4008, 32'hDEAD_BEEF, rd);
      xfer(0, 2, 1'b0, 2'd2, 32'h0000_0008, 32'h0, rd);
      chk("alias", rd, 32'hDEAD_BEEF);

      // Held request, LATENCY 1: accepted every other cycle
      @(negedge clk);
      req_s[1] = 1'b1; wr_s[1] = 1'b0; size_s[1] = 2'd2; addr_s[1] = 32'h0;
      #1;
      for (int i = 0; i < 8; i++) begin
         chk("held_addr_ok", 32'(addr_ok_s[1]), (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("held_data_ok", 32'(data_ok_s[1]), (i % 2 == 0) ? 32'd0 : 32'd1);
         @(negedge clk);
         #1;
      end
      req_s[1] = 1'b0;

      // Reset mid-WAIT, LATENCY 4: write must be dropped
      xfer(2, 4, 1'b1, 2'd2, 32'h0000_0020, 32'h1234_5678, rd);
      @(negedge clk);
      req_s[2] = 1'b1; wr_s[2] = 1'b1; size_s[2] = 2'd2;
      addr_s[2] = 32'h0000_0020; wdata_s[2] = 32'h5555_5555;
      #1 chk("c_addr_ok_T", 32'(addr_ok_s[2]), 32'd1);
      @(negedge clk);
      req_s[2] = 1'b0;
      @(negedge clk);
      rst_s[2] = 1'b1;
      chk("c_no_data_ok_T2", 32'(data_ok_s[2]), 32'd0);
      @(negedge clk);
      rst_s[2] = 1'b0;
      #1 chk("c_addr_ok_post_rst", 32'(addr_ok_s[2]), 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk("c_no_data_ok", 32'(data_ok_s[2]), 32'd0);
         @(negedge clk);
      end
      xfer(2, 4, 1'b0, 2'd2, 32'h0000_0020, 32'h0, rd);
      chk("c_write_dropped", rd, 32'h1234_5678);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
